// File: rtl/clock_time_ctrl.sv
// HH:MM:SS timekeeper with button-driven set mode; drives BCD digits,
// decimal points and blink mask for a downstream seven-segment scanner.
module clock_time_ctrl #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex4,
  output logic [3:0] hex5,
  output logic [5:0] dp,
  output logic [5:0] blank,
  output logic [1:0] mode
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  // Handshake: btn_mode / btn_inc are single-cycle pulses sampled on the
  // rising clk edge; there is no ready, every pulse is consumed that cycle.
  mode_t         state;
  logic [PW-1:0] presc;
  logic [7:0]    hr;
  logic [7:0]    mn;
  logic [7:0]    sc;
  logic          tick;
  logic          phase;

  // Packed BCD {tens, ones} increments; ones 9 carries into tens.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick  = (presc == LAST);
  assign phase = (presc < HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      presc <= '0;
      hr    <= 8'h00;
      mn    <= 8'h00;
      sc    <= 8'h00;
    end else begin
      // Leaving SET_SEC restarts the second so the first tick is a full second away.
      if ((state == SET_SEC && btn_mode) || tick)
        presc <= '0;
      else
        presc <= presc + 1'b1;

      if (btn_mode)
        state <= mode_t'(state + 2'd1);

      if (state == RUN) begin
        if (tick) begin
          sc <= bcd_inc60(sc);
          if (sc == 8'h59) begin
            mn <= bcd_inc60(mn);
            if (mn == 8'h59)
              hr <= bcd_inc24(hr);
          end
        end
      end else if (btn_inc && !btn_mode) begin
        case (state)
          SET_HR:  hr <= bcd_inc24(hr);
          SET_MIN: mn <= bcd_inc60(mn);
          SET_SEC: sc <= 8'h00;
          default: ;
        endcase
      end
    end
  end

  assign hex0 = sc[3:0];
  assign hex1 = sc[7:4];
  assign hex2 = mn[3:0];
  assign hex3 = mn[7:4];
  assign hex4 = hr[3:0];
  assign hex5 = hr[7:4];
  assign mode = state;

  always_comb begin
    dp    = 6'b111111;
    blank = 6'b000000;
    case (state)
      RUN: begin
        dp[2] = ~phase;
        dp[4] = ~phase;
      end
      SET_HR:  blank[5:4] = {2{~phase}};
      SET_MIN: blank[3:2] = {2{~phase}};
      SET_SEC: blank[1:0] = {2{~phase}};
      default: ;
    endcase
  end

endmodule
